// File: rtl/pic_ctrl_gen.sv
// pic_ctrl_gen: fully synchronous 8259-style interrupt controller core.
// Programmed by ICW1/ICW2/ICW4 and then OCW1/OCW2/OCW3 over a small bus.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   wr_en, a0, wdata bus write (a0=0 control word, a0=1 data word)
//   rd_en, rdata    bus read; rdata is registered one cycle after rd_en
//   irq_i           asynchronous request lines (synchronised internally)
//   inta_i          one-cycle acknowledge from the CPU
//   int_o           registered interrupt request to the CPU
//   vec_o, vec_valid_o  vector of the acknowledged level and its strobe
//   init_done_o     high while the controller is in the READY state
module pic_ctrl_gen #(
  parameter int NUM_IRQ     = 8,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               a0,
  input  logic [DW-1:0]      wdata,
  input  logic               rd_en,
  output logic [DW-1:0]      rdata,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               inta_i,
  output logic               int_o,
  output logic [7:0]         vec_o,
  output logic               vec_valid_o,
  output logic               init_done_o
);
  localparam int LVL_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    ST_UNINIT    = 2'd0,
    ST_WAIT_ICW2 = 2'd1,
    ST_WAIT_ICW4 = 2'd2,
    ST_READY     = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [NUM_IRQ-1:0] sync_r [SYNC_STAGES];
  logic [NUM_IRQ-1:0] irq_prev_r;
  logic [NUM_IRQ-1:0] imr_r, imr_s, irr_r, irr_s, isr_r, isr_s;
  logic [LVL_W-1:0]   low_pri_r, low_pri_s;
  logic               aeoi_r, aeoi_s, ltim_r, ltim_s, ic4_r, ic4_s, rsel_r, rsel_s;
  logic [7:LVL_W]     base_r, base_s;
  logic               int_r, int_s, vv_r, vv_s, init_done_r;
  logic [7:0]         vec_r, vec_s;
  logic [DW-1:0]      rdata_r, rdata_s;

  logic [NUM_IRQ-1:0] req_s, rise_s, eoi_clr_s, ack_set_s, ack_clr_s;
  logic [LVL_W:0]     win_s, isr_top_s, any_top_s;
  logic [LVL_W-1:0]   wr_lvl_s, ack_lvl_s;
  logic               icw1_s, ready_s, lvl_ok_s, int_cond_s, inta_acc_s, ack_hit_s;

  // Highest-priority set bit of v, scanning cyclically from the level after lp.
  // Returns {found, level}.
  function automatic logic [LVL_W:0] first_set(input logic [NUM_IRQ-1:0] v,
                                               input logic [LVL_W-1:0]   lp);
    logic [LVL_W:0] r;
    int idx;
    r = '0;
    // Walk from lowest to highest priority so the highest one is written last.
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = int'(lp) + 1 + k;
      if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
      if (v[idx]) r = {1'b1, LVL_W'(idx)};
    end
    return r;
  endfunction

  function automatic logic [NUM_IRQ-1:0] lvl_mask(input logic [LVL_W-1:0] l);
    return NUM_IRQ'(1) << l;
  endfunction

  assign ready_s   = (state_r == ST_READY);
  assign req_s     = irr_r & ~imr_r;
  assign rise_s    = sync_r[SYNC_STAGES-1] & ~irq_prev_r;
  assign win_s     = first_set(req_s, low_pri_r);
  assign isr_top_s = first_set(isr_r, low_pri_r);
  // A request beats in-service only if it appears strictly before any ISR bit.
  assign any_top_s  = first_set(req_s | isr_r, low_pri_r);
  assign int_cond_s = any_top_s[LVL_W] & ~isr_r[any_top_s[LVL_W-1:0]];
  assign wr_lvl_s   = wdata[LVL_W-1:0];
  assign lvl_ok_s   = ({1'b0, wdata[4:0]} < 6'(NUM_IRQ));
  assign icw1_s     = wr_en & ~a0 & (wdata[7:5] == 3'b001);

  // Command decode: configuration registers, state and EOI clear mask.
  always_comb begin
    state_s   = state_r;
    imr_s     = imr_r;
    low_pri_s = low_pri_r;
    aeoi_s    = aeoi_r;
    ltim_s    = ltim_r;
    ic4_s     = ic4_r;
    rsel_s    = rsel_r;
    base_s    = base_r;
    eoi_clr_s = '0;
    if (wr_en && !a0) begin
      case (wdata[7:5])
        3'b001: begin
          ic4_s     = wdata[0];
          ltim_s    = wdata[1];
          imr_s     = '0;
          aeoi_s    = 1'b0;
          low_pri_s = LVL_W'(NUM_IRQ - 1);
          rsel_s    = 1'b0;
          state_s   = ST_WAIT_ICW2;
        end
        3'b010: begin
          if (ready_s && isr_top_s[LVL_W]) eoi_clr_s = lvl_mask(isr_top_s[LVL_W-1:0]);
          else eoi_clr_s = '0;
        end
        3'b011: begin
          if (ready_s && lvl_ok_s) eoi_clr_s = lvl_mask(wr_lvl_s);
          else eoi_clr_s = '0;
        end
        3'b100: begin
          if (ready_s && isr_top_s[LVL_W]) begin
            eoi_clr_s = lvl_mask(isr_top_s[LVL_W-1:0]);
            low_pri_s = isr_top_s[LVL_W-1:0];
          end else begin
            low_pri_s = low_pri_r;
          end
        end
        3'b101: begin
          if (ready_s && lvl_ok_s) low_pri_s = wr_lvl_s;
          else low_pri_s = low_pri_r;
        end
        3'b110: begin
          if (ready_s) rsel_s = wdata[0];
          else rsel_s = rsel_r;
        end
        default: state_s = state_r;
      endcase
    end else if (wr_en && a0) begin
      case (state_r)
        ST_WAIT_ICW2: begin
          base_s  = wdata[7:LVL_W];
          state_s = ic4_r ? ST_WAIT_ICW4 : ST_READY;
        end
        ST_WAIT_ICW4: begin
          aeoi_s  = wdata[1];
          state_s = ST_READY;
        end
        ST_READY: imr_s = wdata[NUM_IRQ-1:0];
        default:  state_s = state_r;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Acknowledge handling, request/in-service update, outputs and readback.
  always_comb begin
    ack_set_s  = '0;
    ack_clr_s  = '0;
    // ICW1 in the same cycle as INTA suppresses the acknowledge entirely.
    inta_acc_s = inta_i & ready_s & ~icw1_s;
    ack_hit_s  = inta_acc_s & int_r & win_s[LVL_W];
    if (ack_hit_s) begin
      ack_lvl_s = win_s[LVL_W-1:0];
      ack_set_s = aeoi_r ? '0 : lvl_mask(win_s[LVL_W-1:0]);
      ack_clr_s = ltim_r ? '0 : lvl_mask(win_s[LVL_W-1:0]);
    end else begin
      ack_lvl_s = LVL_W'(NUM_IRQ - 1);
    end
    if (icw1_s) begin
      irr_s = '0;
      isr_s = '0;
    end else begin
      // A new edge wins over the acknowledge clearing the same bit.
      if (ltim_r) irr_s = sync_r[SYNC_STAGES-1];
      else irr_s = (irr_r & ~ack_clr_s) | rise_s;
      isr_s = (isr_r & ~eoi_clr_s) | ack_set_s;
    end
    int_s = ready_s & int_cond_s & ~inta_acc_s & ~icw1_s;
    vv_s  = inta_acc_s;
    if (inta_acc_s) vec_s = {base_r, ack_lvl_s};
    else vec_s = vec_r;
    if (rd_en) begin
      if (a0) rdata_s = DW'(imr_r);
      else if (rsel_r) rdata_s = DW'(isr_r);
      else rdata_s = DW'(irr_r);
    end else begin
      rdata_s = rdata_r;
    end
  end

  // Request synchroniser chain and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
      irq_prev_r <= '0;
    end else begin
      sync_r[0] <= irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
      irq_prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_UNINIT;
      imr_r       <= '1;
      irr_r       <= '0;
      isr_r       <= '0;
      low_pri_r   <= LVL_W'(NUM_IRQ - 1);
      aeoi_r      <= 1'b0;
      ltim_r      <= 1'b0;
      ic4_r       <= 1'b0;
      rsel_r      <= 1'b0;
      base_r      <= '0;
      int_r       <= 1'b0;
      vv_r        <= 1'b0;
      vec_r       <= 8'h00;
      rdata_r     <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      imr_r       <= imr_s;
      irr_r       <= irr_s;
      isr_r       <= isr_s;
      low_pri_r   <= low_pri_s;
      aeoi_r      <= aeoi_s;
      ltim_r      <= ltim_s;
      ic4_r       <= ic4_s;
      rsel_r      <= rsel_s;
      base_r      <= base_s;
      int_r       <= int_s;
      vv_r        <= vv_s;
      vec_r       <= vec_s;
      rdata_r     <= rdata_s;
      init_done_r <= (state_s == ST_READY);
    end
  end

  assign rdata       = rdata_r;
  assign int_o       = int_r;
  assign vec_o       = vec_r;
  assign vec_valid_o = vv_r;
  assign init_done_o = init_done_r;
endmodule

// File: tb/tb_pic_ctrl_gen.sv
// Directed self-checking bench for pic_ctrl_gen. Two instances share the bus:
// an 8-line/8-bit controller and a 16-line/16-bit one (checked at the end).
module tb_pic_ctrl_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, a0 = 1'b0, rd_en = 1'b0, inta = 1'b0;
  logic [15:0] wdata16 = 16'h0000, irq16 = 16'h0000;
  logic [7:0]  rdata_a, vec_a, vec_b, rd_a;
  logic [15:0] rdata_b, rd_b;
  logic        int_a, vv_a, done_a, int_b, vv_b, done_b;
  int          errors = 0;
  int          checks = 0;

  pic_ctrl_gen u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .a0(a0), .wdata(wdata16[7:0]),
    .rd_en(rd_en), .rdata(rdata_a), .irq_i(irq16[7:0]), .inta_i(inta),
    .int_o(int_a), .vec_o(vec_a), .vec_valid_o(vv_a), .init_done_o(done_a)
  );

  pic_ctrl_gen #(.NUM_IRQ(16), .DW(16)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .a0(a0), .wdata(wdata16),
    .rd_en(rd_en), .rdata(rdata_b), .irq_i(irq16), .inta_i(inta),
    .int_o(int_b), .vec_o(vec_b), .vec_valid_o(vv_b), .init_done_o(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic sel, input logic [15:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; a0 = sel; wdata16 = d;
    @(posedge clk); #1;
    wr_en = 1'b0; a0 = 1'b0;
  endtask

  task automatic rd(input logic sel);
    @(posedge clk); #1;
    rd_en = 1'b1; a0 = sel;
    @(posedge clk); #1;
    rd_en = 1'b0; a0 = 1'b0;
    rd_a = rdata_a; rd_b = rdata_b;
  endtask

  task automatic read_isr(input string tag, input logic [7:0] exp);
    wr(1'b0, 16'h00C1); rd(1'b0); chk(tag, rd_a, exp);
  endtask

  task automatic read_irr(input string tag, input logic [7:0] exp);
    wr(1'b0, 16'h00C0); rd(1'b0); chk(tag, rd_a, exp);
  endtask

  // Waits a bounded number of cycles for int_o of the chosen instance.
  task automatic wait_int(input logic sel, input string tag);
    int n = 0;
    while (((sel ? int_b : int_a) !== 1'b1) && (n < 6)) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, sel ? int_b : int_a, 1'b1);
  endtask

  task automatic ack(input string tag, input logic [7:0] exp_vec);
    @(posedge clk); #1; inta = 1'b1;
    @(posedge clk); #1; inta = 1'b0;
    chk({tag, "_vv"}, vv_a, 1'b1);
    chk({tag, "_vec"}, vec_a, exp_vec);
    chk({tag, "_int0"}, int_a, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_vv_once"}, vv_a, 1'b0);
    chk({tag, "_vec_hold"}, vec_a, exp_vec);
  endtask

  task automatic init(input logic [7:0] icw1, input logic [7:0] icw4);
    wr(1'b0, {8'h00, icw1}); wr(1'b1, 16'h0040); wr(1'b1, {8'h00, icw4});
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_int", int_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_vv", vv_a, 1'b0);
    chk("rst_vec", vec_a, 8'h00);
    chk("rst_rdata", rdata_a, 8'h00);
    rst = 1'b0;
    rd(1'b1); chk("rst_imr", rd_a, 8'hFF);

    // Initialisation and first acknowledge
    init(8'h21, 8'h00);
    chk("init_done", done_a, 1'b1);
    wr(1'b1, 16'h0000);
    irq16 = 16'h0008;
    wait_int(1'b0, "irq3_int");
    irq16 = 16'h0000;
    ack("ack3", 8'h43);
    read_isr("isr_after3", 8'h08);
    read_irr("irr_after3", 8'h00);

    // Fully nested priority
    irq16 = 16'h0020; cyc(6);
    chk("nest_blocked", int_a, 1'b0);
    read_irr("irr_pend5", 8'h20);
    irq16 = 16'h0022;
    wait_int(1'b0, "irq1_int");
    irq16 = 16'h0000;
    ack("ack1", 8'h41);
    read_isr("isr_nested", 8'h0A);
    wr(1'b0, 16'h0040);
    read_isr("isr_ns_eoi", 8'h08);
    wr(1'b0, 16'h007F);
    read_isr("isr_bad_lvl", 8'h08);
    wr(1'b0, 16'h0063);
    read_isr("isr_spec_eoi", 8'h00);
    wait_int(1'b0, "irq5_int");
    ack("ack5", 8'h45);
    wr(1'b0, 16'h0040);

    // Rotating priority
    irq16 = 16'h0004;
    wait_int(1'b0, "irq2_int");
    irq16 = 16'h0000;
    ack("ack2", 8'h42);
    read_isr("isr_lvl2", 8'h04);
    wr(1'b0, 16'h0080);
    read_isr("isr_rot_eoi", 8'h00);
    irq16 = 16'h0012;
    wait_int(1'b0, "irq14_int");
    irq16 = 16'h0000;
    ack("ack_rot4", 8'h44);
    cyc(2);
    chk("rot_nest", int_a, 1'b0);
    wr(1'b0, 16'h0040);
    wait_int(1'b0, "irq1b_int");
    ack("ack_rot1", 8'h41);
    wr(1'b0, 16'h0040);
    wr(1'b0, 16'h00A7);

    // AEOI and masking
    init(8'h21, 8'h02);
    wr(1'b1, 16'h0001);
    irq16 = 16'h0001; cyc(6);
    chk("masked_int", int_a, 1'b0);
    read_irr("masked_irr", 8'h01);
    wr(1'b1, 16'h0000);
    wait_int(1'b0, "unmask_int");
    ack("ack_aeoi", 8'h40);
    read_isr("isr_aeoi", 8'h00);
    read_irr("irr_aeoi", 8'h00);
    irq16 = 16'h0000;

    // Level mode and spurious acknowledge
    init(8'h23, 8'h00);
    wr(1'b1, 16'h0000);
    irq16 = 16'h0004;
    wait_int(1'b0, "lvl_int");
    irq16 = 16'h0000; cyc(5);
    chk("lvl_drop_int", int_a, 1'b0);
    ack("ack_spur", 8'h47);
    read_isr("isr_spur", 8'h00);
    irq16 = 16'h0004;
    wait_int(1'b0, "lvl_int2");
    ack("ack_lvl", 8'h42);
    read_isr("isr_lvl", 8'h04);
    cyc(2);
    chk("lvl_inserv", int_a, 1'b0);
    wr(1'b0, 16'h0040);
    wait_int(1'b0, "lvl_reassert");

    // Reset while a vector strobe is pending
    @(posedge clk); #1; inta = 1'b1;
    @(posedge clk); #1; inta = 1'b0;
    chk("pre_rst_vv", vv_a, 1'b1);
    rst = 1'b1; #1;
    chk("rst_vv_clr", vv_a, 1'b0);
    chk("rst_vec_clr", vec_a, 8'h00);
    irq16 = 16'h0000;
    cyc(1); rst = 1'b0;

    // Reset between ICW1 and ICW2
    wr(1'b0, 16'h0021);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("mid_rst_done", done_a, 1'b0);
    rd(1'b1); chk("mid_rst_imr", rd_a, 8'hFF);
    wr(1'b1, 16'h0040);
    chk("uninit_data", done_a, 1'b0);
    @(posedge clk); #1; inta = 1'b1;
    @(posedge clk); #1; inta = 1'b0;
    chk("uninit_inta", vv_a, 1'b0);

    // 16-line instance
    init(8'h21, 8'h00);
    wr(1'b1, 16'h0000);
    chk("b_done", done_b, 1'b1);
    irq16 = 16'h0800;
    wait_int(1'b1, "b_irq11_int");
    irq16 = 16'h0000;
    @(posedge clk); #1; inta = 1'b1;
    @(posedge clk); #1; inta = 1'b0;
    chk("b_vv", vv_b, 1'b1);
    chk("b_vec", vec_b, 8'h4B);
    wr(1'b0, 16'h00C1); rd(1'b0);
    chk("b_isr", rd_b, 16'h0800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
